if_prefetch_buffer: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RISC-V core, replacing the bare PC register plus IF/ID register pair. It issues sequential reads to the synchronous instruction SRAM, buffers up to DEPTH fetched {pc, instruction} pairs, and hands them to decode over a valid/ready handshake. Decode can stall without losing fetched words, and a single-cycle redirect (branch/jump) flushes the buffer and discards any in-flight read.

---
 rtl/cpu_defs.sv | 11 +
 rtl/fifo_sync.sv | 58 +++++
 rtl/if_prefetch_buffer.sv | 100 ++++++++++
 tb/tb_if_prefetch_buffer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared core definitions for the fetch front end and decode.
//   INSTR_BYTES      : byte stride between sequential instructions
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INSTR        : encoding decode inserts for pipeline bubbles
package cpu_defs;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush, used to buffer fetched {pc, instr} pairs.
// Ports:
//   clk, arst      : clock, asynchronous active-high reset
//   flush          : empties the FIFO at the clock edge (beats push/pop)
//   push, wdata    : write one entry (caller guarantees not full)
//   pop            : remove the head entry (ignored when empty)
//   rdata          : head entry
//   count          : number of occupied entries
module fifo_sync #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign rdata  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch front end: issues sequential reads to the synchronous
// instruction SRAM, buffers returned {pc, instr} pairs and hands them to
// decode over valid/ready. A redirect flushes the buffer and restarts fetch.
// Ports:
//   clk, arst                    : clock, asynchronous active-high reset
//   enable                       : allows new reads (draining continues)
//   redirect_valid, redirect_pc  : flush and restart at redirect_pc (word aligned)
//   imem_ren, imem_addr          : SRAM read strobe and byte address
//   imem_rdata                   : SRAM data, valid the cycle after imem_ren
//   out_valid, out_ready         : decode handshake for the head entry
//   out_instr, out_pc            : head instruction and its address
//   count                        : occupied buffer entries
module if_prefetch_buffer
    import cpu_defs::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         enable,
    input  logic                         redirect_valid,
    input  logic [DATA_W-1:0]            redirect_pc,
    output logic                         imem_ren,
    output logic [DATA_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]           imem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [DATA_W-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0]         fetch_pc;
    logic [DATA_W-1:0]         inflight_pc;
    logic                      inflight;
    logic                      inflight_drop;
    logic [CW:0]               credit_used;
    logic                      issue;
    logic                      push;
    logic                      pop;
    logic [CW-1:0]             fifo_count;
    logic [DATA_W+INSTR_W-1:0] head;

    // Entries already buffered plus the read on its way back must leave room,
    // so a push can never land in a full FIFO.
    assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight);
    assign issue       = !arst && enable && !redirect_valid &&
                         (credit_used < (CW+1)'(DEPTH));

    assign imem_ren  = issue;
    assign imem_addr = fetch_pc;

    // A response arriving alongside a redirect belongs to the abandoned stream.
    assign push = inflight && !inflight_drop && !redirect_valid;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fetch_pc      <= RESET_PC;
            inflight_pc   <= '0;
            inflight      <= 1'b0;
            inflight_drop <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_drop <= redirect_valid;
            if (issue)
                inflight_pc <= fetch_pc;
            if (redirect_valid)
                fetch_pc <= redirect_pc & ~DATA_W'(INSTR_BYTES - 1);
            else if (issue)
                fetch_pc <= fetch_pc + DATA_W'(INSTR_BYTES);
        end
    end

    fifo_sync #(
        .WIDTH (DATA_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .arst  (arst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata ({inflight_pc, imem_rdata}),
        .rdata (head),
        .count (fifo_count)
    );

    // Storage is not reset, so the head is masked to zero while empty.
    assign count     = fifo_count;
    assign out_valid = (fifo_count != '0);
    assign out_pc    = out_valid ? head[DATA_W+INSTR_W-1:INSTR_W] : '0;
    assign out_instr = out_valid ? head[INSTR_W-1:0] : '0;

endmodule

// File: tb/tb_if_prefetch_buffer.sv
module tb_if_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_ren;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  count;

    always #5 clk = ~clk;

    if_prefetch_buffer #(
        .DATA_W   (64),
        .INSTR_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_ren       (imem_ren),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
    );

    // Synchronous SRAM: each word holds the low half of its own address.
    always @(posedge clk) begin
        if (imem_ren)
            imem_rdata <= imem_addr[31:0];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered pcs, pcs of reads in flight, next fetch pc.
    logic [63:0] m_q[$];
    logic [63:0] m_pend[$];
    logic [63:0] m_pc = 64'h0;
    bit          m_iss;
    bit          model_chk = 1'b0;

    function automatic bit m_ren();
        return !arst && enable && !redirect_valid &&
               ((m_q.size() + m_pend.size()) < DEPTH);
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_q.delete();
            m_pend.delete();
            m_pc = 64'h0;
        end else begin
            m_iss = m_ren();
            if (redirect_valid) begin
                m_q.delete();
                m_pend.delete();
                m_pc = {redirect_pc[63:2], 2'b00};
            end else begin
                if (out_ready && m_q.size() != 0)
                    void'(m_q.pop_front());
                while (m_pend.size() != 0)
                    m_q.push_back(m_pend.pop_front());
                if (m_iss) begin
                    m_pend.push_back(m_pc);
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    end

    task automatic model_check();
        chk("m_valid", out_valid, m_q.size() != 0);
        chk("m_count", count, m_q.size());
        chk("m_ren", imem_ren, m_ren());
        chk("m_addr", imem_addr, m_pc);
        if (m_q.size() != 0) begin
            chk("m_pc", out_pc, m_q[0]);
            chk("m_instr", out_instr, {32'h0, m_q[0][31:0]});
        end
    endtask

    // Called at a falling edge: apply inputs, settle, compare against model.
    task automatic drive(input bit en, input bit rdy, input bit rv, input logic [63:0] rpc);
        enable         = en;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (model_chk)
            model_check();
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    typedef struct {
        bit          en;
        bit          rdy;
        bit          rv;
        logic [63:0] rpc;
        bit          e_valid;
        logic [63:0] e_pc;
        logic [2:0]  e_count;
        bit          e_ren;
        logic [63:0] e_addr;
    } vec_t;

    vec_t tv[16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        bit          en_r, rdy_r, rv_r;
        logic [63:0] rpc_r;

        // Stream from reset, backpressure to full, then redirect with a read in flight.
        tv[0]  = '{1, 1, 0, 64'h0,    0, 64'h0,    3'd0, 1, 64'h0};
        tv[1]  = '{1, 1, 0, 64'h0,    0, 64'h0,    3'd0, 1, 64'h4};
        tv[2]  = '{1, 1, 0, 64'h0,    1, 64'h0,    3'd1, 1, 64'h8};
        tv[3]  = '{1, 1, 0, 64'h0,    1, 64'h4,    3'd1, 1, 64'hC};
        tv[4]  = '{1, 0, 0, 64'h0,    1, 64'h8,    3'd1, 1, 64'h10};
        tv[5]  = '{1, 0, 0, 64'h0,    1, 64'h8,    3'd2, 1, 64'h14};
        tv[6]  = '{1, 0, 0, 64'h0,    1, 64'h8,    3'd3, 0, 64'h18};
        tv[7]  = '{1, 0, 0, 64'h0,    1, 64'h8,    3'd4, 0, 64'h18};
        tv[8]  = '{1, 1, 0, 64'h0,    1, 64'h8,    3'd4, 0, 64'h18};
        tv[9]  = '{1, 1, 0, 64'h0,    1, 64'hC,    3'd3, 1, 64'h18};
        tv[10] = '{1, 1, 0, 64'h0,    1, 64'h10,   3'd2, 1, 64'h1C};
        tv[11] = '{1, 1, 1, 64'h1003, 1, 64'h14,   3'd2, 0, 64'h20};
        tv[12] = '{1, 1, 0, 64'h0,    0, 64'h0,    3'd0, 1, 64'h1000};
        tv[13] = '{1, 1, 0, 64'h0,    0, 64'h0,    3'd0, 1, 64'h1004};
        tv[14] = '{1, 1, 0, 64'h0,    1, 64'h1000, 3'd1, 1, 64'h1008};
        tv[15] = '{1, 1, 0, 64'h0,    1, 64'h1004, 3'd1, 1, 64'h100C};

        // Reset state with enable already high.
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ren", imem_ren, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_pc", out_pc, 64'h0);
        chk("rst_instr", out_instr, 64'h0);
        arst      = 1'b0;
        model_chk = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].en, tv[i].rdy, tv[i].rv, tv[i].rpc);
            chk($sformatf("tv%0d_valid", i), out_valid, tv[i].e_valid);
            chk($sformatf("tv%0d_count", i), count, tv[i].e_count);
            chk($sformatf("tv%0d_ren", i), imem_ren, tv[i].e_ren);
            chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].e_addr);
            if (tv[i].e_valid) begin
                chk($sformatf("tv%0d_pc", i), out_pc, tv[i].e_pc);
                chk($sformatf("tv%0d_instr", i), out_instr, {32'h0, tv[i].e_pc[31:0]});
            end
            tick();
        end

        // Redirect while full and stalled.
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 64'h0);
            tick();
        end
        drive(1, 0, 0, 64'h0);
        chk("full_count", count, 4);
        chk("full_ren", imem_ren, 0);
        tick();
        drive(1, 0, 1, 64'h200);
        tick();
        drive(1, 0, 0, 64'h0);
        chk("full_flush_count", count, 0);
        chk("full_flush_valid", out_valid, 0);
        tick();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive(1, 1, 0, 64'h0);
            if (out_valid) begin
                seen = 1'b1;
                chk("full_redir_pc", out_pc, 64'h200);
            end
            tick();
        end
        if (!seen)
            chk("full_redir_timeout", 0, 1);

        // Enable gating and address wrap.
        drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        drive(1, 1, 0, 64'h0);
        chk("wrap_ren", imem_ren, 1);
        chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        drive(0, 1, 0, 64'h0);
        chk("gate_ren0", imem_ren, 0);
        chk("gate_addr", imem_addr, 64'h0);
        tick();
        drive(0, 1, 0, 64'h0);
        chk("gate_ren1", imem_ren, 0);
        chk("gate_valid", out_valid, 1);
        chk("gate_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("gate_instr", out_instr, 64'hFFFF_FFFC);
        tick();
        drive(0, 1, 0, 64'h0);
        chk("gate_empty", out_valid, 0);
        tick();
        drive(1, 1, 0, 64'h0);
        chk("wrap_ren2", imem_ren, 1);
        chk("wrap_addr2", imem_addr, 64'h0);
        tick();
        drive(1, 1, 0, 64'h0);
        tick();
        drive(1, 1, 0, 64'h0);
        chk("wrap_valid", out_valid, 1);
        chk("wrap_pc", out_pc, 64'h0);
        tick();

        // Mid-operation asynchronous reset with three entries buffered.
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive(1, 0, 0, 64'h0);
            if (count == 3)
                seen = 1'b1;
            else
                tick();
        end
        if (!seen)
            chk("mrst_fill_timeout", 0, 1);
        #2;
        arst = 1'b1;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_count", count, 0);
        chk("mrst_ren", imem_ren, 0);
        chk("mrst_addr", imem_addr, 64'h0);
        chk("mrst_pc", out_pc, 64'h0);
        out_ready = 1'b1;
        arst      = 1'b0;
        tick();
        drive(1, 1, 0, 64'h0);
        chk("mrst_addr1", imem_addr, 64'h4);
        chk("mrst_valid1", out_valid, 0);
        tick();
        drive(1, 1, 0, 64'h0);
        chk("mrst_valid2", out_valid, 1);
        chk("mrst_pc2", out_pc, 64'h0);
        tick();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            en_r  = ($urandom_range(0, 9) < 8);
            rdy_r = ($urandom_range(0, 9) < 7);
            rv_r  = ($urandom_range(0, 29) == 0);
            rpc_r = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
                rpc_r = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, rpc_r[3:0]};
            drive(en_r, rdy_r, rv_r, rpc_r);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
